// File: rtl/alarm_controller.sv
// Alarm clock controller: arms and triggers on an hour/minute match at second 0,
// rings with a timeout, supports a bounded number of snoozes, and can be dismissed.
module alarm_controller #(
  parameter int SNOOZE_S   = 300,
  parameter int RING_S     = 60,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic [4:0] alm_hour,
  input  logic [5:0] alm_min,
  input  logic       adjust,
  input  logic       arm_toggle,
  input  logic       dismiss,
  input  logic       snooze,
  output logic       armed,
  output logic       ringing,
  output logic       led_alarm,
  output logic       snoozing,
  output logic [2:0] snooze_used
);

  localparam int RING_W  = $clog2(RING_S + 1);
  localparam int SNZ_W   = $clog2(SNOOZE_S + 1);

  localparam logic [1:0] DISARMED = 2'd0;
  localparam logic [1:0] ARMED    = 2'd1;
  localparam logic [1:0] RINGING  = 2'd2;
  localparam logic [1:0] SNOOZE   = 2'd3;

  logic [1:0]        state_reg, state_next;
  logic [RING_W-1:0] ring_cnt_reg, ring_cnt_next;
  logic [SNZ_W-1:0]  snz_cnt_reg, snz_cnt_next;
  logic [2:0]        used_reg, used_next;
  logic              led_reg, led_next;
  logic              trigger;

  // cur_sec==0 is only true on the first tick of the minute, so this fires once per match.
  assign trigger = tick_1hz && !adjust && (cur_hour == alm_hour) &&
                   (cur_min == alm_min) && (cur_sec == 6'd0);

  always_comb begin
    state_next    = state_reg;
    ring_cnt_next = ring_cnt_reg;
    snz_cnt_next  = snz_cnt_reg;
    used_next     = used_reg;
    led_next      = led_reg;

    if (adjust && (state_reg == RINGING || state_reg == SNOOZE)) begin
      state_next = ARMED;
    end else if (arm_toggle) begin
      state_next = (state_reg == DISARMED) ? ARMED : DISARMED;
    end else begin
      case (state_reg)
        ARMED: begin
          if (trigger) begin
            state_next    = RINGING;
            ring_cnt_next = '0;
            used_next     = '0;
            led_next      = 1'b1;
          end
        end
        RINGING: begin
          if (dismiss) begin
            state_next = ARMED;
          end else if (snooze && (used_reg < 3'(MAX_SNOOZE))) begin
            state_next   = SNOOZE;
            snz_cnt_next = SNZ_W'(SNOOZE_S);
            used_next    = used_reg + 3'd1;
          end else if (tick_1hz) begin
            if (ring_cnt_reg == RING_W'(RING_S - 1)) begin
              state_next    = ARMED;
              ring_cnt_next = '0;
            end else begin
              ring_cnt_next = ring_cnt_reg + RING_W'(1);
              led_next      = !led_reg;
            end
          end
        end
        SNOOZE: begin
          if (dismiss) begin
            state_next = ARMED;
          end else if (tick_1hz) begin
            if (snz_cnt_reg == SNZ_W'(1)) begin
              state_next    = RINGING;
              snz_cnt_next  = '0;
              ring_cnt_next = '0;
              led_next      = 1'b1;
            end else if (snz_cnt_reg != '0) begin
              snz_cnt_next = snz_cnt_reg - SNZ_W'(1);
            end
          end
        end
        default: state_next = DISARMED;
      endcase
    end

    // The LED only lives in RINGING; leaving for any reason blanks it and idles the counters.
    if (state_next != RINGING) begin
      led_next      = 1'b0;
      ring_cnt_next = '0;
    end
    if (state_next != SNOOZE) begin
      snz_cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= DISARMED;
      ring_cnt_reg <= '0;
      snz_cnt_reg  <= '0;
      used_reg     <= '0;
      led_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ring_cnt_reg <= ring_cnt_next;
      snz_cnt_reg  <= snz_cnt_next;
      used_reg     <= used_next;
      led_reg      <= led_next;
    end
  end

  assign armed       = (state_reg != DISARMED);
  assign ringing     = (state_reg == RINGING);
  assign snoozing    = (state_reg == SNOOZE);
  assign led_alarm   = led_reg;
  assign snooze_used = used_reg;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with short ring/snooze parameters.
module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       rst, tick_1hz, adjust, arm_toggle, dismiss, snooze;
  logic [4:0] cur_hour, alm_hour;
  logic [5:0] cur_min, cur_sec, alm_min;
  logic       armed, ringing, led_alarm, snoozing;
  logic [2:0] snooze_used;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alarm_controller #(.SNOOZE_S(3), .RING_S(4), .MAX_SNOOZE(2)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .alm_hour(alm_hour), .alm_min(alm_min),
    .adjust(adjust), .arm_toggle(arm_toggle), .dismiss(dismiss), .snooze(snooze),
    .armed(armed), .ringing(ringing), .led_alarm(led_alarm),
    .snoozing(snoozing), .snooze_used(snooze_used)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    $display("check %-24s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick_at(input logic [5:0] m, input logic [5:0] s);
    cur_min = m; cur_sec = s; tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1; cyc(); snooze = 1'b0;
  endtask

  task automatic pulse_arm();
    arm_toggle = 1'b1; cyc(); arm_toggle = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 0; adjust = 0; arm_toggle = 0; dismiss = 0; snooze = 0;
    cur_hour = 5'd7; cur_min = 6'd29; cur_sec = 6'd59;
    alm_hour = 5'd7; alm_min = 6'd30;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_armed", armed, 0);
    chk("rst_ringing", ringing, 0);
    chk("rst_led", led_alarm, 0);
    chk("rst_snoozing", snoozing, 0);
    chk("rst_used", snooze_used, 0);

    // Basic ring and timeout
    pulse_arm();
    chk("arm_armed", armed, 1);
    tick_at(6'd29, 6'd59);
    chk("pre_match_ringing", ringing, 0);
    tick_at(6'd30, 6'd0);
    chk("trig_ringing", ringing, 1);
    chk("trig_led", led_alarm, 1);
    tick_at(6'd30, 6'd1);
    chk("ring1_led", led_alarm, 0);
    tick_at(6'd30, 6'd2);
    chk("ring2_led", led_alarm, 1);
    tick_at(6'd30, 6'd3);
    chk("ring3_ringing", ringing, 1);
    tick_at(6'd30, 6'd4);
    chk("timeout_ringing", ringing, 0);
    chk("timeout_armed", armed, 1);
    chk("timeout_led", led_alarm, 0);
    tick_at(6'd30, 6'd5);
    chk("no_retrig_ringing", ringing, 0);

    // Snooze sequence up to the limit
    alm_min = 6'd31;
    tick_at(6'd31, 6'd0);
    chk("ev2_ringing", ringing, 1);
    pulse_snooze();
    chk("snz1_snoozing", snoozing, 1);
    chk("snz1_used", snooze_used, 1);
    chk("snz1_led", led_alarm, 0);
    tick_at(6'd31, 6'd1);
    tick_at(6'd31, 6'd2);
    chk("snz1_still", snoozing, 1);
    pulse_snooze();
    chk("snz_in_snooze_used", snooze_used, 1);
    tick_at(6'd31, 6'd3);
    chk("rering_ringing", ringing, 1);
    chk("rering_led", led_alarm, 1);
    chk("rering_used", snooze_used, 1);
    pulse_snooze();
    chk("snz2_used", snooze_used, 2);
    tick_at(6'd31, 6'd4);
    tick_at(6'd31, 6'd5);
    tick_at(6'd31, 6'd6);
    chk("rering2_ringing", ringing, 1);
    pulse_snooze();
    chk("snz3_ignored_ring", ringing, 1);
    chk("snz3_ignored_snz", snoozing, 0);
    chk("snz3_used", snooze_used, 2);

    // Dismiss beats snooze in the same cycle
    dismiss = 1'b1; snooze = 1'b1;
    cyc();
    dismiss = 1'b0; snooze = 1'b0;
    chk("dismiss_ringing", ringing, 0);
    chk("dismiss_snoozing", snoozing, 0);
    chk("dismiss_armed", armed, 1);
    chk("dismiss_used", snooze_used, 2);
    tick_at(6'd31, 6'd7);
    chk("post_dismiss_ring", ringing, 0);

    // Adjust suppresses the trigger and cancels a snooze
    alm_min = 6'd32;
    adjust = 1'b1;
    tick_at(6'd32, 6'd0);
    adjust = 1'b0;
    chk("adjust_no_ring", ringing, 0);
    alm_min = 6'd33;
    tick_at(6'd33, 6'd0);
    chk("ev3_ringing", ringing, 1);
    chk("ev3_used_cleared", snooze_used, 0);
    pulse_snooze();
    chk("ev3_snoozing", snoozing, 1);
    adjust = 1'b1; cyc(); adjust = 1'b0;
    chk("adj_snz_snoozing", snoozing, 0);
    chk("adj_snz_armed", armed, 1);

    // Reset mid-ring aborts the event
    alm_min = 6'd34;
    tick_at(6'd34, 6'd0);
    chk("ev4_ringing", ringing, 1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst_ring_ringing", ringing, 0);
    chk("rst_ring_armed", armed, 0);
    chk("rst_ring_led", led_alarm, 0);
    pulse_arm();
    tick_at(6'd34, 6'd1);
    chk("rst_no_retrig", ringing, 0);

    // arm_toggle during SNOOZE disarms
    alm_min = 6'd35;
    tick_at(6'd35, 6'd0);
    pulse_snooze();
    chk("ev5_snoozing", snoozing, 1);
    pulse_arm();
    chk("toggle_snz_armed", armed, 0);
    chk("toggle_snz_snoozing", snoozing, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- SNOOZE_S, 300, snooze duration in seconds (>=2)
- RING_S, 60, ring timeout in seconds (>=2)
- MAX_SNOOZE, 3, snoozes allowed per alarm event (1..7)
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  system clock, sole clock
- rst  in  1  synchronous, active-high reset
- tick_1hz  in  1  one-cycle pulse once per second, aligned with time update
- cur_hour  in  5  current hour, 0..23
- cur_min  in  6  current minute, 0..59
- cur_sec  in  6  current second, 0..59
- alm_hour  in  5  alarm hour, 0..23
- alm_min  in  6  alarm minute, 0..59
- adjust  in  1  level, high while user edits time or alarm
- arm_toggle  in  1  debounced one-cycle pulse, arm/disarm
- dismiss  in  1  debounced one-cycle pulse (center button)
- snooze  in  1  debounced one-cycle pulse (up or down button)
- armed  out  1  alarm armed (states ARMED, RINGING, SNOOZE)
- ringing  out  1  high in RINGING only, drives buzzer
- led_alarm  out  1  blinks at 0.5 Hz (toggles per tick) while ringing
- snoozing  out  1  high in SNOOZE only
- snooze_used  out  3  snoozes consumed in current alarm event

Function
REQ-003 FSM SHALL have four states: DISARMED, ARMED, RINGING, SNOOZE; all outputs registered, decoded from state/counters.
REQ-004 Trigger T SHALL be: state ARMED, adjust low, tick_1hz high, cur_hour==alm_hour, cur_min==alm_min, cur_sec==0; T moves ARMED->RINGING next cycle.
REQ-005 Trigger SHALL fire at most once per matching minute (cur_sec==0 only on its first tick); no trigger while adjust high.
REQ-006 Entering RINGING from ARMED SHALL clear ring counter, set snooze_used=0, set led_alarm=1.
REQ-007 In RINGING each tick_1hz SHALL increment ring counter and toggle led_alarm; tick that makes count equal RING_S SHALL return to ARMED (timeout).
REQ-008 In RINGING, dismiss SHALL go to ARMED next cycle.
REQ-009 In RINGING, snooze with snooze_used<MAX_SNOOZE SHALL go to SNOOZE, load snooze counter=SNOOZE_S, increment snooze_used; with snooze_used==MAX_SNOOZE snooze SHALL be ignored.
REQ-010 In SNOOZE each tick_1hz SHALL decrement snooze counter; tick that takes it from 1 to 0 SHALL re-enter RINGING with ring counter cleared, led_alarm=1, snooze_used retained.
REQ-011 In SNOOZE, dismiss SHALL go to ARMED; snooze SHALL be ignored.
REQ-012 arm_toggle SHALL move DISARMED->ARMED, ARMED->DISARMED, RINGING/SNOOZE->DISARMED.
REQ-013 adjust high in RINGING or SNOOZE SHALL force ARMED next cycle.
REQ-014 Same-cycle priority SHALL be: rst > adjust > arm_toggle > dismiss > snooze > tick-driven transitions (trigger, timeout, snooze expiry).
REQ-015 led_alarm SHALL be 0 whenever state is not RINGING; snooze_used SHALL hold its value in ARMED/DISARMED until next trigger.
REQ-016 Counters SHALL be sized for their parameter max and SHALL never wrap.

Reset
REQ-017 rst high at a clk edge SHALL set state DISARMED, all counters 0, armed=0, ringing=0, led_alarm=0, snoozing=0, snooze_used=0, regardless of state.
REQ-018 Reset mid-RINGING or mid-SNOOZE SHALL abort the event; no re-trigger until ARMED and a new T.

Verification (bench uses SNOOZE_S=3, RING_S=4, MAX_SNOOZE=2)
REQ-019 Arm, alarm 07:30, time 07:29:59->07:30:00 with tick -> ringing=1 next cycle, led_alarm=1; 4 ticks later ringing=0, armed=1.
REQ-020 Ringing, snooze pulse -> snoozing=1, snooze_used=1; 3 ticks -> ringing=1; snooze again -> snooze_used=2; third snooze ignored, ringing stays 1.
REQ-021 Ringing, dismiss and snooze in same cycle -> ARMED, snooze_used unchanged; time 07:30:01 tick -> no re-trigger.
REQ-022 Match at 07:30:00 with adjust=1 -> no ring; adjust asserted during SNOOZE -> ARMED next cycle.
REQ-023 rst during RINGING -> all outputs 0 next cycle, armed=0; arm_toggle during SNOOZE -> DISARMED.
